// File: rtl/reg_file_pkg.sv
// Shared types for the AXI-lite user register file and its initiators.
// Provides the register map lookup used by axi_lite_reg_master when AXI_LITE_REG_MASTER_ADDR_CHECK_EN is set.
package reg_file_pkg;

   localparam int REG_FILE_AXI_ADDR_WIDTH = 8;
   localparam int REG_FILE_AXI_DATA_WIDTH = 32;
   localparam int REG_FILE_NUM_REGS       = 8;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   typedef struct packed {
      logic                                   rnw;
      logic [REG_FILE_AXI_ADDR_WIDTH-1:0]     addr;
      logic [REG_FILE_AXI_DATA_WIDTH-1:0]     wdata;
      logic [REG_FILE_AXI_DATA_WIDTH/8-1:0]   wstrb;
   } reg_cmd_t;

   typedef struct packed {
      logic [REG_FILE_AXI_DATA_WIDTH-1:0] rdata;
      axi_resp_t                          resp;
   } reg_rsp_t;

   typedef struct packed {
      logic       entry_found;
      logic [2:0] index;
   } reg_item_t;

   // Registers occupy consecutive words from 0x00; the byte offset within a word is ignored.
   function automatic reg_item_t get_reg_item_from_addr(input logic [REG_FILE_AXI_ADDR_WIDTH-1:0] addr);
      reg_item_t                          item;
      logic [REG_FILE_AXI_ADDR_WIDTH-1:0] word;
      word             = addr >> 2;
      item.entry_found = (word < REG_FILE_NUM_REGS[REG_FILE_AXI_ADDR_WIDTH-1:0]);
      item.index       = word[2:0];
      return item;
   endfunction

endpackage

// File: rtl/axi_lite_reg_master.sv
// AXI4-Lite initiator: one register read or write per command, one outstanding transaction.
// Optional address pre-check against the register map: AXI_LITE_REG_MASTER_ADDR_CHECK_EN.
module axi_lite_reg_master
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_FILE_AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_rnw,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    busy,
   output logic [2:0]              state_dbg,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   // Every channel transfers on the rising edge where valid & ready are both high;
   // a valid, once raised, stays high with stable payload until that edge.

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   state_t   state, state_nxt;
   reg_cmd_t cmd_q;
   reg_rsp_t rsp_q;
   logic     aw_done, w_done;
   logic     ready_en;
   logic     addr_miss;
   logic     accept;

   assign accept = cmd_valid & cmd_ready;

`ifdef AXI_LITE_REG_MASTER_ADDR_CHECK_EN
   reg_item_t lookup;

   always_comb lookup = get_reg_item_from_addr(cmd_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_miss <= 1'b0;
      end else if (accept) begin
         addr_miss <= !lookup.entry_found;
      end
   end
`else
   assign addr_miss = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
      end
   end

   // A missed lookup still passes through WR_AW_W/RD_AR for one cycle with its valids masked.
   always_comb begin
      state_nxt     = state;
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      rsp_valid     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = ready_en;
            if (cmd_valid && ready_en) state_nxt = cmd_rnw ? RD_AR : WR_AW_W;
         end
         WR_AW_W: begin
            m_axi_awvalid = !aw_done && !addr_miss;
            m_axi_wvalid  = !w_done && !addr_miss;
            if (addr_miss) state_nxt = RSP;
            else if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WR_B;
         end
         WR_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_nxt = RSP;
         end
         RD_AR: begin
            m_axi_arvalid = !addr_miss;
            if (addr_miss) state_nxt = RSP;
            else if (m_axi_arready) state_nxt = RD_R;
         end
         RD_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_nxt = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q   <= '0;
         rsp_q   <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q   <= '{rnw: cmd_rnw, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
         if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
         case (state)
            WR_AW_W, RD_AR: if (addr_miss) rsp_q <= '{rdata: '0, resp: RESP_DECERR};
            WR_B:           if (m_axi_bvalid) rsp_q <= '{rdata: '0, resp: m_axi_bresp};
            RD_R:           if (m_axi_rvalid) rsp_q <= '{rdata: m_axi_rdata, resp: m_axi_rresp};
            default: ;
         endcase
      end
   end

   assign m_axi_awaddr = cmd_q.addr & ALIGN_MASK;
   assign m_axi_araddr = cmd_q.addr & ALIGN_MASK;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wdata  = cmd_q.wdata;
   assign m_axi_wstrb  = cmd_q.wstrb;
   assign rsp_rdata    = rsp_q.rdata;
   assign rsp_resp     = rsp_q.resp;
   assign busy         = (state != IDLE);
   assign state_dbg    = state;

endmodule
